// File: rtl/reg_file_2w2r.sv
// reg_file_2w2r: parametrised two-write / two-read register file.
// - Per-entry valid bits, registered read ports, collision flag (port B wins).
// - Clear engine sweeps one entry per cycle, DEPTH cycles, without a global reset.
// - Optional write-first bypass on the read ports: define REGFILE_BYPASS_EN.
//   Without it the read ports are read-first (pre-write contents).
module reg_file_2w2r #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              write_enable_A,
    input  logic              write_enable_B,
    input  logic [ADDR_W-1:0] write_address_A,
    input  logic [ADDR_W-1:0] write_address_B,
    input  logic [DATA_W-1:0] data_input_A,
    input  logic [DATA_W-1:0] data_input_B,
    input  logic              read_enable_A,
    input  logic              read_enable_B,
    input  logic [ADDR_W-1:0] read_address_A,
    input  logic [ADDR_W-1:0] read_address_B,
    output logic [DATA_W-1:0] data_output_A,
    output logic [DATA_W-1:0] data_output_B,
    output logic              read_valid_A,
    output logic              read_valid_B,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              write_conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic we_a;
    logic we_b;
    logic sweep;

    // Writes are only accepted while idle; strobes during a sweep are dropped.
    always_comb begin
        sweep = (state_q == StClear);
        we_a  = write_enable_A && !sweep;
        we_b  = write_enable_B && !sweep;
    end

    // Read lookup for one port: {valid, data}. Bypass only sees accepted writes.
    function automatic logic [DATA_W:0] read_entry(input logic [ADDR_W-1:0] addr);
        logic [DATA_W:0] res;
        res = {valid_q[addr], mem_q[addr]};
`ifdef REGFILE_BYPASS_EN
        if (we_b && write_address_B == addr) begin
            res = {1'b1, data_input_B};
        end else if (we_a && write_address_A == addr) begin
            res = {1'b1, data_input_A};
        end
`endif
        return res;
    endfunction

    // Clear-sweep FSM with registered busy flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            clear_busy <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clear_req) begin
                        state_q    <= StClear;
                        ptr_q      <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                StClear: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_q    <= StIdle;
                        clear_busy <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: sweep clears the pointed entry, otherwise B overrides A.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sweep && ptr_q == ADDR_W'(i)) begin
                    mem_q[i]   <= '0;
                    valid_q[i] <= 1'b0;
                end else if (we_b && write_address_B == ADDR_W'(i)) begin
                    mem_q[i]   <= data_input_B;
                    valid_q[i] <= 1'b1;
                end else if (we_a && write_address_A == ADDR_W'(i)) begin
                    mem_q[i]   <= data_input_A;
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    // Collision flag: one-cycle pulse after both accepted writes hit one address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            write_conflict <= 1'b0;
        end else begin
            write_conflict <= we_a && we_b && (write_address_A == write_address_B);
        end
    end

    // Registered read ports; hold their value when not enabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_output_A <= '0;
            data_output_B <= '0;
            read_valid_A  <= 1'b0;
            read_valid_B  <= 1'b0;
        end else begin
            if (read_enable_A) begin
                {read_valid_A, data_output_A} <= read_entry(read_address_A);
            end
            if (read_enable_B) begin
                {read_valid_B, data_output_B} <= read_entry(read_address_B);
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed testbench for reg_file_2w2r (DATA_W=8, ADDR_W=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_reg_file_2w2r;

    logic       CLK = 1'b0;
    logic       RST;
    logic       write_enable_A, write_enable_B;
    logic [1:0] write_address_A, write_address_B;
    logic [7:0] data_input_A, data_input_B;
    logic       read_enable_A, read_enable_B;
    logic [1:0] read_address_A, read_address_B;
    logic [7:0] data_output_A, data_output_B;
    logic       read_valid_A, read_valid_B;
    logic       clear_req;
    logic       clear_busy;
    logic       write_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_2w2r #(.DATA_W(8), .ADDR_W(2)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .write_enable_A (write_enable_A),
        .write_enable_B (write_enable_B),
        .write_address_A(write_address_A),
        .write_address_B(write_address_B),
        .data_input_A   (data_input_A),
        .data_input_B   (data_input_B),
        .read_enable_A  (read_enable_A),
        .read_enable_B  (read_enable_B),
        .read_address_A (read_address_A),
        .read_address_B (read_address_B),
        .data_output_A  (data_output_A),
        .data_output_B  (data_output_B),
        .read_valid_A   (read_valid_A),
        .read_valid_B   (read_valid_B),
        .clear_req      (clear_req),
        .clear_busy     (clear_busy),
        .write_conflict (write_conflict)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        write_enable_A = 0; write_enable_B = 0;
        write_address_A = 0; write_address_B = 0;
        data_input_A = 0; data_input_B = 0;
        read_enable_A = 0; read_enable_B = 0;
        read_address_A = 0; read_address_B = 0;
        clear_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({data_output_A, data_output_B, read_valid_A, read_valid_B,
             clear_busy, write_conflict} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got A=%h B=%h vA=%b vB=%b busy=%b conf=%b want all 0",
                     data_output_A, data_output_B, read_valid_A, read_valid_B,
                     clear_busy, write_conflict);
        end
        RST = 1'b0;
        for (int a = 0; a < 4; a++) begin
            read_enable_A = 1; read_enable_B = 1;
            read_address_A = 2'(a); read_address_B = 2'(3 - a);
            @(negedge CLK);
            n_checks++;
            if ({read_valid_A, data_output_A, read_valid_B, data_output_B} !== 18'h0) begin
                n_fail++;
                $display("FAIL reset_read addr%0d got A=%h/%b B=%h/%b want 00/0 both",
                         a, data_output_A, read_valid_A, data_output_B, read_valid_B);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        write_enable_A = 1; write_address_A = 1; data_input_A = 8'hA5;
        write_enable_B = 1; write_address_B = 2; data_input_B = 8'h3C;
        @(negedge CLK);
        idle_inputs();
        read_enable_A = 1; read_address_A = 1;
        read_enable_B = 1; read_address_B = 2;
        @(negedge CLK);
        n_checks++;
        if (data_output_A !== 8'hA5 || read_valid_A !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_A got %h/%b want a5/1", data_output_A, read_valid_A);
        end
        n_checks++;
        if (data_output_B !== 8'h3C || read_valid_B !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_B got %h/%b want 3c/1", data_output_B, read_valid_B);
        end
        n_checks++;
        if (write_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rd_conflict got %b want 0", write_conflict);
        end
        // Disabled read ports must hold even when the address moves.
        read_enable_A = 0; read_address_A = 0;
        read_enable_B = 0; read_address_B = 0;
        @(negedge CLK);
        n_checks++;
        if (data_output_A !== 8'hA5 || data_output_B !== 8'h3C) begin
            n_fail++;
            $display("FAIL read_hold got A=%h B=%h want a5 3c", data_output_A, data_output_B);
        end
        idle_inputs();
    endtask

    task automatic test_conflict();
        write_enable_A = 1; write_address_A = 3; data_input_A = 8'h11;
        write_enable_B = 1; write_address_B = 3; data_input_B = 8'h22;
        @(negedge CLK);
        n_checks++;
        if (write_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_pulse got %b want 1", write_conflict);
        end
        idle_inputs();
        read_enable_A = 1; read_address_A = 3;
        @(negedge CLK);
        n_checks++;
        if (write_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_clear got %b want 0", write_conflict);
        end
        n_checks++;
        if (data_output_A !== 8'h22 || read_valid_A !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_winner got %h/%b want 22/1", data_output_A, read_valid_A);
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        write_enable_A = 1; write_address_A = 0; data_input_A = 8'h10;
        write_enable_B = 1; write_address_B = 1; data_input_B = 8'h11;
        @(negedge CLK);
        write_address_A = 2; data_input_A = 8'h12;
        write_address_B = 3; data_input_B = 8'h13;
        @(negedge CLK);
        idle_inputs();
        clear_req = 1;
        @(negedge CLK);
        // Sweep cycle 1: entry 0 cleared at the next edge; writes must drop.
        clear_req = 0;
        write_enable_A = 1; write_address_A = 0; data_input_A = 8'hFF;
        write_enable_B = 1; write_address_B = 0; data_input_B = 8'hFF;
        read_enable_A = 1; read_address_A = 3;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (clear_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL clear_busy_high cyc%0d got %b want 1", c, clear_busy);
            end
            @(negedge CLK);
            if (c == 0) begin
                n_checks++;
                if (data_output_A !== 8'h13 || read_valid_A !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clear_midread got %h/%b want 13/1",
                             data_output_A, read_valid_A);
                end
                n_checks++;
                if (write_conflict !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clear_noconflict got %b want 0", write_conflict);
                end
                idle_inputs();
            end
        end
        n_checks++;
        if (clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_busy_low got %b want 0", clear_busy);
        end
        for (int a = 0; a < 4; a++) begin
            read_enable_A = 1; read_address_A = 2'(a);
            read_enable_B = 1; read_address_B = 2'(a);
            @(negedge CLK);
            n_checks++;
            if ({read_valid_A, data_output_A, read_valid_B, data_output_B} !== 18'h0) begin
                n_fail++;
                $display("FAIL clear_read addr%0d got A=%h/%b B=%h/%b want 00/0",
                         a, data_output_A, read_valid_A, data_output_B, read_valid_B);
            end
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        logic [7:0] exp_d;
        logic       exp_v;
`ifdef REGFILE_BYPASS_EN
        exp_d = 8'h5A; exp_v = 1'b1;
`else
        exp_d = 8'h00; exp_v = 1'b0;
`endif
        write_enable_A = 1; write_address_A = 0; data_input_A = 8'h5A;
        read_enable_A = 1; read_address_A = 0;
        @(negedge CLK);
        n_checks++;
        if (data_output_A !== exp_d || read_valid_A !== exp_v) begin
            n_fail++;
            $display("FAIL same_cycle_read got %h/%b want %h/%b",
                     data_output_A, read_valid_A, exp_d, exp_v);
        end
        write_enable_A = 0;
        @(negedge CLK);
        n_checks++;
        if (data_output_A !== 8'h5A || read_valid_A !== 1'b1) begin
            n_fail++;
            $display("FAIL after_write_read got %h/%b want 5a/1", data_output_A, read_valid_A);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        clear_req = 1;
        @(negedge CLK);
        clear_req = 0;
        @(negedge CLK);
        n_checks++;
        if (clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midsweep_busy got %b want 1", clear_busy);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if (clear_busy !== 1'b0 || data_output_A !== 8'h00 || read_valid_A !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_reset got busy=%b A=%h vA=%b want 0 00 0",
                     clear_busy, data_output_A, read_valid_A);
        end
        @(negedge CLK);
        RST = 1'b0;
        write_enable_A = 1; write_address_A = 2; data_input_A = 8'h77;
        @(negedge CLK);
        idle_inputs();
        read_enable_A = 1; read_address_A = 2;
        read_enable_B = 1; read_address_B = 0;
        @(negedge CLK);
        n_checks++;
        if (data_output_A !== 8'h77 || read_valid_A !== 1'b1 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_write got %h/%b busy=%b want 77/1 busy 0",
                     data_output_A, read_valid_A, clear_busy);
        end
        n_checks++;
        if (data_output_B !== 8'h00 || read_valid_B !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_addr0 got %h/%b want 00/0", data_output_B, read_valid_B);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_clear();
        test_bypass();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_2w2r.md
# reg_file_2w2r

Parametrised two-write / two-read register file with per-entry valid tracking, registered read ports and a sequenced clear engine. It is the next generation of the 4x8 dual-port register storage: width and depth are generic, write collisions are resolved deterministically and flagged, and the whole array can be wiped without a global reset. It sits between the datapath control and the ALU operand muxes.

## Interface
- DATA_W, default 8: entry width in bits.
- ADDR_W, default 2: address width in bits; depth DEPTH = 2**ADDR_W (derived, not overridable).
- CLK  input  1  single clock, all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- write_enable_A / write_enable_B  input  1  write strobe per port.
- write_address_A / write_address_B  input  ADDR_W  write address per port.
- data_input_A / data_input_B  input  DATA_W  write data per port.
- read_enable_A / read_enable_B  input  1  read strobe per port.
- read_address_A / read_address_B  input  ADDR_W  read address per port.
- data_output_A / data_output_B  output  DATA_W  registered read data.
- read_valid_A / read_valid_B  output  1  registered: the entry read has been written since last reset/clear.
- clear_req  input  1  start a clear sweep (sampled only when idle).
- clear_busy  output  1  high while the clear sweep runs.
- write_conflict  output  1  registered one-cycle pulse: both ports wrote the same address.

## Operation
- Reset (RST high, async): all entries 0, all valid bits 0, data_output_A/B = 0, read_valid_A/B = 0, clear_busy = 0, write_conflict = 0, FSM = IDLE, sweep pointer = 0.
- Writes (IDLE only): each enabled port writes its data and sets the entry's valid bit at the edge.
- Same-address double write: port B wins; write_conflict = 1 for exactly the following cycle. Different addresses: both commit.
- Reads: with read_enable high, data_output and read_valid load the addressed entry at the edge; with read_enable low, both hold their previous values.
- FSM IDLE: clear_req = 1 -> CLEAR, pointer = 0, clear_busy = 1 from next cycle.
- FSM CLEAR: each cycle, entry[pointer] = 0 and its valid bit = 0; pointer increments. After writing entry DEPTH-1 -> IDLE, clear_busy = 0. The sweep takes exactly DEPTH cycles.
- During CLEAR: write strobes are ignored (dropped, no conflict flag); clear_req is ignored; reads remain legal and return current contents (cleared or not yet cleared).
- A write and a clear_req in the same IDLE cycle: the write commits, then the sweep erases it.
- RST asserted mid-sweep: immediate return to the reset state; the sweep is abandoned.

## Timing
- Read latency 1 cycle: address presented before edge N, data valid after edge N.
- Write -> read visibility: a write at edge N is readable by a read issued for edge N+1 (and by a same-cycle read only if bypass is enabled, see Configuration).
- clear_req sampled at edge N -> clear_busy high after N, low after edge N+DEPTH; first accepted write at edge N+DEPTH+1.
- write_conflict is asserted after the colliding edge and deasserted one edge later unless another collision occurs.

## Configuration
- REGFILE_BYPASS_EN defined: write-first. A read whose address matches a committed write in the same cycle returns the new data with read_valid = 1. If both ports hit that address, port B's data is returned. Bypass never applies to writes dropped during CLEAR.
- Not defined: read-first. A same-cycle read returns the pre-write contents and valid bit.

## Test plan
- Reset, then read all 4 addresses on both ports -> data 0x00, read_valid 0 everywhere.
- Write A addr1 = 0xA5 and B addr2 = 0x3C at edge N, read A addr1 / B addr2 at edge N+1 -> 0xA5 / 0x3C, valid 1, write_conflict 0.
- Write A addr3 = 0x11 and B addr3 = 0x22 at the same edge -> addr3 reads 0x22; write_conflict high for exactly one cycle.
- Fill all entries, pulse clear_req -> clear_busy high for 4 cycles; a write of 0xFF issued mid-sweep is dropped; afterwards all reads give 0x00 with valid 0.
- Write addr0 = 0x5A and read addr0 in the same cycle -> 0x5A with REGFILE_BYPASS_EN defined, the previous value (0x00, valid 0 after reset) without it.
- Assert RST two cycles into a sweep -> clear_busy 0, outputs 0 immediately; a new write then commits normally.
